// File: rtl/dac_seq_pkg.sv
// Shared definitions for the AD7849 sample feeder.
// Holds the playback FSM encoding and the default widths.
package dac_seq_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int GAP_W_DEF  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_ARM,
    S_WAIT_DONE,
    S_WAIT_CLR,
    S_GAP
  } state_t;

endpackage

// File: rtl/dac_seq_ram.sv
// Waveform store: simple dual-port RAM, synchronous write, registered read.
// A write and a read of the same address in one cycle return the old word.
module dac_seq_ram
  import dac_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              tx_clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset so it maps onto block RAM; contents are defined only once written.
  always_ff @(posedge tx_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dac_wave_sequencer.sv
// Plays a RAM-held waveform into the AD7849 serializer over its trig/done handshake,
// single-shot or looped, with a programmable gap between samples.
module dac_wave_sequencer
  import dac_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int GAP_W  = GAP_W_DEF
) (
  input  logic              tx_clk,
  input  logic              OPB_RST,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic              START,
  input  logic              STOP,
  input  logic              LOOP,
  input  logic [ADDR_W:0]   LENGTH,
  input  logic [GAP_W-1:0]  GAP,
  input  logic              DAC_DONE,
  output logic              DAC_TRIG,
  output logic [DATA_W-1:0] DAC_DATA,
  output logic              BUSY,
  output logic [ADDR_W-1:0] SAMPLE_IDX,
  output logic              SEQ_DONE
);

  localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [GAP_W-1:0]  GAP_ONE = {{(GAP_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              trig_q, trig_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              seq_done_q, seq_done_d;
  logic              stop_pend_q, stop_pend_d;
  logic              load_shadow;

  logic [ADDR_W:0]   len_q;
  logic              loop_q;
  logic [GAP_W-1:0]  gap_q;

  logic [ADDR_W:0]   len_clamped;
  logic              is_last;
  logic [DATA_W-1:0] ram_q;

  dac_seq_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .tx_clk  (tx_clk),
    .wr_en   (WR_EN),
    .wr_addr (WR_ADDR),
    .wr_data (WR_DATA),
    .rd_addr (idx_q),
    .rd_data (ram_q)
  );

  assign len_clamped = (LENGTH > DEPTH) ? DEPTH : LENGTH;
  assign is_last     = ({1'b0, idx_q} == (len_q - LEN_ONE));

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    gap_cnt_d   = gap_cnt_q;
    trig_d      = trig_q;
    data_d      = data_q;
    seq_done_d  = 1'b0;
    stop_pend_d = stop_pend_q;
    load_shadow = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (START && !STOP && (LENGTH != '0)) begin
          load_shadow = 1'b1;
          idx_d       = '0;
          stop_pend_d = 1'b0;
          state_d     = S_RD;
        end
      end
      S_RD: begin
        if (STOP) begin
          seq_done_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (STOP) begin
          seq_done_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          data_d  = ram_q;
          trig_d  = 1'b1;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        // A stop here must let the DAC frame finish; trig only drops on done.
        if (STOP) begin
          stop_pend_d = 1'b1;
        end
        if (DAC_DONE) begin
          trig_d  = 1'b0;
          state_d = S_WAIT_CLR;
        end
      end
      S_WAIT_CLR: begin
        if (STOP) begin
          stop_pend_d = 1'b1;
        end
        if (!DAC_DONE) begin
          if (stop_pend_q || STOP || (is_last && !loop_q)) begin
            seq_done_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            idx_d     = is_last ? '0 : idx_q + IDX_ONE;
            gap_cnt_d = gap_q;
            state_d   = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (STOP) begin
          seq_done_d = 1'b1;
          state_d    = S_IDLE;
        end else if (gap_cnt_q == '0) begin
          state_d = S_RD;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of block order.
  always_ff @(posedge tx_clk or posedge OPB_RST) begin
    if (OPB_RST) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      gap_cnt_q   <= '0;
      trig_q      <= 1'b0;
      data_q      <= '0;
      seq_done_q  <= 1'b0;
      stop_pend_q <= 1'b0;
      len_q       <= '0;
      loop_q      <= 1'b0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_cnt_q   <= gap_cnt_d;
      trig_q      <= trig_d;
      data_q      <= data_d;
      seq_done_q  <= seq_done_d;
      stop_pend_q <= stop_pend_d;
      if (load_shadow) begin
        len_q  <= len_clamped;
        loop_q <= LOOP;
        gap_q  <= GAP;
      end
    end
  end

  assign DAC_TRIG   = trig_q;
  assign DAC_DATA   = data_q;
  assign BUSY       = (state_q != S_IDLE);
  assign SAMPLE_IDX = idx_q;
  assign SEQ_DONE   = seq_done_q;

endmodule

// File: tb/tb_dac_wave_sequencer.sv
// Scoreboard bench for dac_wave_sequencer with a DAC responder model.
// Stimulus pushes expected samples; a monitor pops one per DAC_TRIG rise.
module tb_dac_wave_sequencer;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 16;
  localparam int GAP_W    = 16;
  localparam int DONE_DLY = 2;

  logic              tx_clk = 1'b0;
  logic              OPB_RST = 1'b1;
  logic              WR_EN = 1'b0;
  logic [ADDR_W-1:0] WR_ADDR = '0;
  logic [DATA_W-1:0] WR_DATA = '0;
  logic              START = 1'b0;
  logic              STOP = 1'b0;
  logic              LOOP = 1'b0;
  logic [ADDR_W:0]   LENGTH = '0;
  logic [GAP_W-1:0]  GAP = '0;
  logic              DAC_DONE = 1'b0;
  logic              DAC_TRIG;
  logic [DATA_W-1:0] DAC_DATA;
  logic              BUSY;
  logic [ADDR_W-1:0] SAMPLE_IDX;
  logic              SEQ_DONE;

  dac_wave_sequencer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .GAP_W  (GAP_W)
  ) dut (
    .tx_clk     (tx_clk),
    .OPB_RST    (OPB_RST),
    .WR_EN      (WR_EN),
    .WR_ADDR    (WR_ADDR),
    .WR_DATA    (WR_DATA),
    .START      (START),
    .STOP       (STOP),
    .LOOP       (LOOP),
    .LENGTH     (LENGTH),
    .GAP        (GAP),
    .DAC_DONE   (DAC_DONE),
    .DAC_TRIG   (DAC_TRIG),
    .DAC_DATA   (DAC_DATA),
    .BUSY       (BUSY),
    .SAMPLE_IDX (SAMPLE_IDX),
    .SEQ_DONE   (SEQ_DONE)
  );

  always #5 tx_clk = ~tx_clk;

  int cyc = 0;
  always @(posedge tx_clk) cyc = cyc + 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  int   rise_count    = 0;
  int   seq_done_cnt  = 0;
  int   last_rise_cyc = 0;
  int   last_gap      = -1;
  int   drop_cyc      = 0;
  bit   drop_valid    = 1'b0;
  int   start_cyc     = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // DAC model: done rises DONE_DLY cycles into trig, falls once trig has dropped.
  initial begin
    int hi_cnt = 0;
    forever begin
      @(negedge tx_clk);
      if (OPB_RST) begin
        DAC_DONE = 1'b0;
        hi_cnt   = 0;
      end else if (DAC_TRIG) begin
        if (!DAC_DONE) begin
          hi_cnt++;
          if (hi_cnt >= DONE_DLY) DAC_DONE = 1'b1;
        end
      end else begin
        hi_cnt = 0;
        if (DAC_DONE) begin
          DAC_DONE   = 1'b0;
          drop_cyc   = cyc;
          drop_valid = 1'b1;
        end
      end
    end
  end

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    logic              prev_trig = 1'b0;
    logic [DATA_W-1:0] rise_data = '0;
    logic [ADDR_W-1:0] rise_idx  = '0;
    exp_t              e;
    forever begin
      @(posedge tx_clk);
      #1;
      if (OPB_RST) begin
        prev_trig = 1'b0;
      end else begin
        if (SEQ_DONE) seq_done_cnt++;
        if (DAC_TRIG && !prev_trig) begin
          rise_count++;
          last_rise_cyc = cyc;
          rise_data     = DAC_DATA;
          rise_idx      = SAMPLE_IDX;
          // Gap counted from the edge that first sees DONE low to the edge raising TRIG.
          if (drop_valid) begin
            last_gap   = cyc - (drop_cyc + 1);
            drop_valid = 1'b0;
          end
          check("trig_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("trig_data", 32'(DAC_DATA), 32'(e.data));
            check("trig_idx", 32'(SAMPLE_IDX), 32'(e.idx));
          end
        end else if (DAC_TRIG) begin
          check("hold_stable", {DAC_DATA, SAMPLE_IDX}, {rise_data, rise_idx});
        end else if (prev_trig) begin
          check("trig_fall_after_done", 32'(DAC_DONE), 32'd1);
        end
        prev_trig = DAC_TRIG;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] i);
    exp_t e;
    e.data = d;
    e.idx  = i;
    exp_q.push_back(e);
  endtask

  task automatic ram_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    WR_EN   = 1'b1;
    WR_ADDR = a;
    WR_DATA = d;
    @(negedge tx_clk);
    WR_EN   = 1'b0;
  endtask

  task automatic start_run(input logic [ADDR_W:0] len, input logic lp, input logic [GAP_W-1:0] g);
    LENGTH    = len;
    LOOP      = lp;
    GAP       = g;
    START     = 1'b1;
    start_cyc = cyc;
    @(negedge tx_clk);
    START     = 1'b0;
  endtask

  task automatic wait_rises(input int target, input string name);
    int n = 0;
    while (rise_count < target && n < 2000) begin
      @(negedge tx_clk);
      n++;
    end
    check(name, 32'(rise_count >= target), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (BUSY && n < 2000) begin
      @(negedge tx_clk);
      n++;
    end
    check(name, 32'(BUSY), 32'd0);
  endtask

  initial begin
    int base_r;
    int base_d;
    int n;
    bit busy_seen;

    repeat (2) @(negedge tx_clk);
    check("rst_trig", 32'(DAC_TRIG), 32'd0);
    check("rst_data", 32'(DAC_DATA), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_idx", 32'(SAMPLE_IDX), 32'd0);
    check("rst_seq_done", 32'(SEQ_DONE), 32'd0);
    OPB_RST = 1'b0;
    @(negedge tx_clk);

    // 1: single shot of three samples, no gap
    ram_write(8'd0, 16'h1111);
    ram_write(8'd1, 16'h2222);
    ram_write(8'd2, 16'h3333);
    base_r = rise_count;
    base_d = seq_done_cnt;
    push_exp(16'h1111, 8'd0);
    push_exp(16'h2222, 8'd1);
    push_exp(16'h3333, 8'd2);
    start_run(9'd3, 1'b0, 16'd0);
    wait_rises(base_r + 1, "t1_first_trig");
    // START presented -> RD, ARM, WAIT_DONE entry: TRIG rises on the third edge.
    check("t1_start_latency", 32'(last_rise_cyc - start_cyc), 32'd3);
    wait_idle("t1_idle");
    check("t1_trig_count", 32'(rise_count - base_r), 32'd3);
    check("t1_seq_done", 32'(seq_done_cnt - base_d), 32'd1);
    check("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // 2 + 3: two-sample loop with GAP=5, then STOP while TRIG is high
    base_r = rise_count;
    base_d = seq_done_cnt;
    push_exp(16'h1111, 8'd0);
    push_exp(16'h2222, 8'd1);
    push_exp(16'h1111, 8'd0);
    push_exp(16'h2222, 8'd1);
    push_exp(16'h1111, 8'd0);
    start_run(9'd2, 1'b1, 16'd5);
    wait_rises(base_r + 5, "t2_loop_trigs");
    // GAP+1 gap cycles, then RD and ARM: 5 + 3.
    check("t2_gap_latency", 32'(last_gap), 32'd8);
    check("t3_trig_high_at_stop", 32'(DAC_TRIG), 32'd1);
    STOP = 1'b1;
    wait_idle("t3_idle");
    STOP = 1'b0;
    repeat (20) @(negedge tx_clk);
    check("t3_trig_count", 32'(rise_count - base_r), 32'd5);
    check("t3_seq_done", 32'(seq_done_cnt - base_d), 32'd1);
    check("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // 4: LENGTH=0 start, then START and STOP together
    base_r    = rise_count;
    base_d    = seq_done_cnt;
    busy_seen = 1'b0;
    LENGTH    = '0;
    START     = 1'b1;
    repeat (4) begin
      @(negedge tx_clk);
      busy_seen |= BUSY;
    end
    LENGTH = 9'd3;
    STOP   = 1'b1;
    repeat (4) begin
      @(negedge tx_clk);
      busy_seen |= BUSY;
    end
    START = 1'b0;
    STOP  = 1'b0;
    repeat (4) begin
      @(negedge tx_clk);
      busy_seen |= BUSY;
    end
    check("t4_busy_never", 32'(busy_seen), 32'd0);
    check("t4_no_trig", 32'(rise_count - base_r), 32'd0);
    check("t4_no_seq_done", 32'(seq_done_cnt - base_d), 32'd0);

    // 5: rewrite address 1 mid-loop, then STOP during the gap
    base_r = rise_count;
    base_d = seq_done_cnt;
    push_exp(16'h1111, 8'd0);
    push_exp(16'h2222, 8'd1);
    push_exp(16'h3333, 8'd2);
    push_exp(16'h1111, 8'd0);
    push_exp(16'hABCD, 8'd1);
    start_run(9'd3, 1'b1, 16'd2);
    wait_rises(base_r + 3, "t5_first_pass");
    ram_write(8'd1, 16'hABCD);
    wait_rises(base_r + 5, "t5_second_pass");
    n = 0;
    while (DAC_TRIG && n < 100) begin
      @(negedge tx_clk);
      n++;
    end
    check("t5_trig_fell", 32'(DAC_TRIG), 32'd0);
    @(negedge tx_clk);
    STOP = 1'b1;
    @(negedge tx_clk);
    check("t5_stop_in_gap_idle", 32'(BUSY), 32'd0);
    STOP = 1'b0;
    repeat (10) @(negedge tx_clk);
    check("t5_trig_count", 32'(rise_count - base_r), 32'd5);
    check("t5_seq_done", 32'(seq_done_cnt - base_d), 32'd1);
    check("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // 6: reset in WAIT_DONE, then a fresh run from index 0
    base_r = rise_count;
    push_exp(16'h1111, 8'd0);
    start_run(9'd3, 1'b0, 16'd0);
    wait_rises(base_r + 1, "t6_first_trig");
    OPB_RST = 1'b1;
    #1;
    check("t6_rst_trig", 32'(DAC_TRIG), 32'd0);
    check("t6_rst_data", 32'(DAC_DATA), 32'd0);
    check("t6_rst_busy", 32'(BUSY), 32'd0);
    check("t6_rst_idx", 32'(SAMPLE_IDX), 32'd0);
    repeat (2) @(negedge tx_clk);
    OPB_RST = 1'b0;
    @(negedge tx_clk);
    base_r = rise_count;
    base_d = seq_done_cnt;
    push_exp(16'h1111, 8'd0);
    push_exp(16'hABCD, 8'd1);
    start_run(9'd2, 1'b0, 16'd0);
    wait_idle("t6_idle");
    check("t6_trig_count", 32'(rise_count - base_r), 32'd2);
    check("t6_seq_done", 32'(seq_done_cnt - base_d), 32'd1);
    check("t6_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
